// File: rtl/signal_router.sv
// Registered NUM_IN x NUM_OUT crossbar with a valid/ready reconfiguration handshake.
// Every changeover runs a mute window so outputs never show a mixed or torn selection.
module signal_router #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_IN      = 2,
  parameter int NUM_OUT     = 2,
  parameter int SEL_WIDTH   = 1,
  parameter int MUTE_CYCLES = 4,
  parameter int MUTE_MODE   = 0
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_IN*DATA_WIDTH-1:0]    s_data,
  input  logic [NUM_OUT*SEL_WIDTH-1:0]    cfg_sel,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0]   m_data,
  output logic                            busy
);

  localparam int CNT_W = (MUTE_CYCLES > 0) ? $clog2(MUTE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (MUTE_CYCLES > 0) ? CNT_W'(MUTE_CYCLES - 1) : '0;

  function automatic logic [NUM_OUT*SEL_WIDTH-1:0] default_sel();
    logic [NUM_OUT*SEL_WIDTH-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      v[k*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(k % NUM_IN);
    return v;
  endfunction

  localparam logic [NUM_OUT*SEL_WIDTH-1:0] SEL_RESET = default_sel();

  typedef enum logic [1:0] {
    IDLE,
    MUTE,
    APPLY
  } state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [NUM_OUT*SEL_WIDTH-1:0]   active_sel;
  logic [NUM_OUT*SEL_WIDTH-1:0]   pending_sel;
  logic [NUM_OUT*DATA_WIDTH-1:0]  routed;

  // A select value with no matching input leaves that output at zero.
  always_comb begin
    routed = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      for (int unsigned i = 0; i < NUM_IN; i++)
        if (active_sel[k*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(i))
          routed[k*DATA_WIDTH +: DATA_WIDTH] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      cnt         <= '0;
      active_sel  <= SEL_RESET;
      pending_sel <= SEL_RESET;
      m_data      <= '0;
      cfg_ready   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m_data <= routed;
          if (cfg_valid && cfg_ready) begin
            pending_sel <= cfg_sel;
            cfg_ready   <= 1'b0;
            busy        <= 1'b1;
            cnt         <= CNT_LOAD;
            state       <= (MUTE_CYCLES > 0) ? MUTE : APPLY;
          end else begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        MUTE: begin
          if (MUTE_MODE != 0) m_data <= '0;
          if (cnt == '0) state <= APPLY;
          else           cnt   <= cnt - 1'b1;
        end
        APPLY: begin
          // All outputs adopt the new selection together on this edge.
          if (MUTE_MODE != 0) m_data <= '0;
          active_sel <= pending_sel;
          cfg_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_router.sv
// Bench for signal_router: three parameterisations share stimulus, one is checked at a time
// against a transaction-level model of the changeover window.
module tb_signal_router;

  localparam int DW = 16;
  localparam int MC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn = 1'b0;
  logic [DW-1:0] in_ch [0:3];
  logic [1:0]    req   [0:2];
  logic          vld   [0:2];

  logic [2*DW-1:0] a_s, a_m;  logic [1:0] a_sel; logic a_rdy, a_busy;
  logic [4*DW-1:0] b_s;       logic [3*DW-1:0] b_m; logic [5:0] b_sel; logic b_rdy, b_busy;
  logic [3*DW-1:0] c_s;       logic [2*DW-1:0] c_m; logic [3:0] c_sel; logic c_rdy, c_busy;

  assign a_s   = {in_ch[1], in_ch[0]};
  assign a_sel = {req[1][0], req[0][0]};
  assign b_s   = {in_ch[3], in_ch[2], in_ch[1], in_ch[0]};
  assign b_sel = {req[2], req[1], req[0]};
  assign c_s   = {in_ch[2], in_ch[1], in_ch[0]};
  assign c_sel = {req[1], req[0]};

  signal_router #(.DATA_WIDTH(DW), .NUM_IN(2), .NUM_OUT(2), .SEL_WIDTH(1),
                  .MUTE_CYCLES(MC), .MUTE_MODE(0)) dut_a (
    .aclk(clk), .aresetn(aresetn), .s_data(a_s), .cfg_sel(a_sel), .cfg_valid(vld[0]),
    .cfg_ready(a_rdy), .m_data(a_m), .busy(a_busy));

  signal_router #(.DATA_WIDTH(DW), .NUM_IN(4), .NUM_OUT(3), .SEL_WIDTH(2),
                  .MUTE_CYCLES(MC), .MUTE_MODE(1)) dut_b (
    .aclk(clk), .aresetn(aresetn), .s_data(b_s), .cfg_sel(b_sel), .cfg_valid(vld[1]),
    .cfg_ready(b_rdy), .m_data(b_m), .busy(b_busy));

  signal_router #(.DATA_WIDTH(DW), .NUM_IN(3), .NUM_OUT(2), .SEL_WIDTH(2),
                  .MUTE_CYCLES(0), .MUTE_MODE(0)) dut_c (
    .aclk(clk), .aresetn(aresetn), .s_data(c_s), .cfg_sel(c_sel), .cfg_valid(vld[2]),
    .cfg_ready(c_rdy), .m_data(c_m), .busy(c_busy));

  int checks = 0;
  int errors = 0;

  // Configuration of the instance currently under test.
  int cur, nin, nout, mc;
  bit mzero;
  logic [1:0] selmask;

  // Reference model state.
  logic [DW-1:0] em [0:2];
  logic erdy, ebusy;
  int act [0:2];
  int pend [0:2];
  bit pending;
  int edge_n = 0;
  int t_acc = 0;

  logic [DW-1:0] gm [0:2];
  logic grdy, gbusy;

  task automatic select_dut(input int d);
    cur = d;
    case (d)
      0: begin nin = 2; nout = 2; mc = MC; mzero = 1'b0; selmask = 2'b01; end
      1: begin nin = 4; nout = 3; mc = MC; mzero = 1'b1; selmask = 2'b11; end
      default: begin nin = 3; nout = 2; mc = 0; mzero = 1'b0; selmask = 2'b11; end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      em[k] = '0;
      act[k] = k % nin;
      pend[k] = act[k];
    end
    erdy = 1'b0;
    ebusy = 1'b0;
    pending = 1'b0;
  endtask

  // One rising edge: an accepted request mutes edges t_acc+1 .. t_acc+mc+1, the last of which
  // installs the new selection.
  task automatic model_edge();
    bit acc, muted;
    acc = erdy && vld[cur];
    edge_n++;
    muted = pending && (edge_n > t_acc) && (edge_n <= t_acc + mc + 1);
    for (int k = 0; k < nout; k++) begin
      if (muted) begin
        if (mzero) em[k] = '0;
      end else begin
        em[k] = (act[k] < nin) ? in_ch[act[k]] : '0;
      end
    end
    if (muted && edge_n == t_acc + mc + 1) begin
      for (int k = 0; k < nout; k++) act[k] = pend[k];
      pending = 1'b0;
    end
    if (acc) begin
      pending = 1'b1;
      t_acc = edge_n;
      for (int k = 0; k < nout; k++) pend[k] = int'(req[k] & selmask);
    end
    erdy = !pending;
    ebusy = pending;
  endtask

  task automatic sample();
    gm[2] = '0;
    case (cur)
      0: begin gm[0] = a_m[15:0]; gm[1] = a_m[31:16]; grdy = a_rdy; gbusy = a_busy; end
      1: begin gm[0] = b_m[15:0]; gm[1] = b_m[31:16]; gm[2] = b_m[47:32];
               grdy = b_rdy; gbusy = b_busy; end
      default: begin gm[0] = c_m[15:0]; gm[1] = c_m[31:16]; grdy = c_rdy; gbusy = c_busy; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    sample();
  endtask

  task automatic do_reset(input int d);
    select_dut(d);
    for (int k = 0; k < 3; k++) begin vld[k] = 1'b0; req[k] = '0; end
    aresetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    select_dut(0);
    aresetn = 1'b0;
    in_ch[0] = 16'h1111; in_ch[1] = 16'h2222;
    model_reset();
    repeat (2) @(posedge clk);
    #1 sample();
    checks++;
    if (gm[0] !== 16'h0 || gm[1] !== 16'h0) begin
      errors++; $display("FAIL reset_mdata got %h_%h exp 0000_0000", gm[1], gm[0]);
    end
    checks++;
    if (grdy !== 1'b0 || gbusy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got rdy=%b busy=%b exp 0 0", grdy, gbusy);
    end
    @(negedge clk);
    aresetn = 1'b1;
    tick();
    checks++;
    if (grdy !== 1'b1 || gbusy !== 1'b0) begin
      errors++; $display("FAIL reset_first_edge got rdy=%b busy=%b exp 1 0", grdy, gbusy);
    end
    checks++;
    if ({gm[1], gm[0]} !== 32'h2222_1111) begin
      errors++; $display("FAIL reset_route got %h_%h exp 2222_1111", gm[1], gm[0]);
    end
  endtask

  task automatic test_swap_hold();
    logic [DW-1:0] frozen [0:1];
    logic [DW-1:0] pre0, pre1;
    int guard, low;
    do_reset(0);
    in_ch[0] = 16'h0100; in_ch[1] = 16'h0800;
    req[0] = 2'd1; req[1] = 2'd0; vld[0] = 1'b1;
    guard = 0;
    do begin
      tick();
      in_ch[0]++; in_ch[1]++; guard++;
    end while (!pending && guard < 8);
    vld[0] = 1'b0;
    checks++;
    if (grdy !== 1'b0 || gbusy !== 1'b1) begin
      errors++; $display("FAIL swap_accept got rdy=%b busy=%b exp 0 1", grdy, gbusy);
    end
    frozen[0] = em[0]; frozen[1] = em[1];
    low = 1;
    for (int c = 0; c < MC + 4; c++) begin
      pre0 = in_ch[0]; pre1 = in_ch[1];
      tick();
      for (int k = 0; k < nout; k++) begin
        checks++;
        if (gm[k] !== em[k]) begin
          errors++; $display("FAIL swap_m%0d cyc %0d got %h exp %h", k, c, gm[k], em[k]);
        end
      end
      checks++;
      if ({grdy, gbusy} !== {erdy, ebusy}) begin
        errors++; $display("FAIL swap_flags cyc %0d got %b%b exp %b%b", c, grdy, gbusy, erdy, ebusy);
      end
      if (grdy === 1'b0) low++;
      if (c <= MC) begin
        checks++;
        if (gm[0] !== frozen[0] || gm[1] !== frozen[1]) begin
          errors++; $display("FAIL swap_frozen cyc %0d got %h_%h exp %h_%h",
                             c, gm[1], gm[0], frozen[1], frozen[0]);
        end
      end
      if (c == MC + 1) begin
        checks++;
        if (gm[0] !== pre1 || gm[1] !== pre0) begin
          errors++; $display("FAIL swap_switch got %h_%h exp %h_%h", gm[1], gm[0], pre0, pre1);
        end
      end
      in_ch[0]++; in_ch[1]++;
    end
    checks++;
    if (low !== MC + 1) begin
      errors++; $display("FAIL swap_ready_low got %0d exp %0d", low, MC + 1);
    end
  endtask

  task automatic test_zero_fanout();
    logic [DW-1:0] pre2;
    int guard;
    do_reset(1);
    for (int i = 0; i < 4; i++) in_ch[i] = DW'($urandom_range(1, 16'hFFFF));
    for (int k = 0; k < 3; k++) req[k] = 2'd2;
    vld[1] = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (!pending && guard < 8);
    vld[1] = 1'b0;
    for (int c = 0; c < MC + 4; c++) begin
      for (int i = 0; i < 4; i++) in_ch[i] = DW'($urandom_range(1, 16'hFFFF));
      pre2 = in_ch[2];
      tick();
      for (int k = 0; k < nout; k++) begin
        checks++;
        if (gm[k] !== em[k]) begin
          errors++; $display("FAIL fanout_m%0d cyc %0d got %h exp %h", k, c, gm[k], em[k]);
        end
      end
      checks++;
      if ({grdy, gbusy} !== {erdy, ebusy}) begin
        errors++; $display("FAIL fanout_flags cyc %0d got %b%b exp %b%b", c, grdy, gbusy, erdy, ebusy);
      end
      if (c <= MC) begin
        checks++;
        if (gm[0] !== 16'h0 || gm[1] !== 16'h0 || gm[2] !== 16'h0) begin
          errors++; $display("FAIL fanout_zero cyc %0d got %h_%h_%h exp 0", c, gm[2], gm[1], gm[0]);
        end
      end
      if (c == MC + 1) begin
        checks++;
        if (gm[0] !== pre2 || gm[1] !== pre2 || gm[2] !== pre2) begin
          errors++; $display("FAIL fanout_in2 got %h_%h_%h exp %h", gm[2], gm[1], gm[0], pre2);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] pre2;
    int guard, low;
    do_reset(2);
    req[0] = 2'd2; req[1] = 2'd3; vld[2] = 1'b1;
    guard = 0;
    do begin
      for (int i = 0; i < 3; i++) in_ch[i] = DW'($urandom_range(1, 16'hFFFF));
      tick(); guard++;
    end while (!pending && guard < 8);
    vld[2] = 1'b0;
    low = (grdy === 1'b0) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 3; i++) in_ch[i] = DW'($urandom_range(1, 16'hFFFF));
      pre2 = in_ch[2];
      tick();
      if (grdy === 1'b0) low++;
      for (int k = 0; k < nout; k++) begin
        checks++;
        if (gm[k] !== em[k]) begin
          errors++; $display("FAIL oor_m%0d cyc %0d got %h exp %h", k, c, gm[k], em[k]);
        end
      end
      checks++;
      if ({grdy, gbusy} !== {erdy, ebusy}) begin
        errors++; $display("FAIL oor_flags cyc %0d got %b%b exp %b%b", c, grdy, gbusy, erdy, ebusy);
      end
      if (c >= 1) begin
        checks++;
        if (gm[0] !== pre2 || gm[1] !== 16'h0) begin
          errors++; $display("FAIL oor_route cyc %0d got %h_%h exp 0000_%h", c, gm[1], gm[0], pre2);
        end
      end
    end
    checks++;
    if (low !== 1) begin
      errors++; $display("FAIL zero_mute_ready_low got %0d exp 1", low);
    end
  endtask

  task automatic test_ignore_in_mute();
    logic [DW-1:0] pre1;
    int guard;
    do_reset(0);
    req[0] = 2'd1; req[1] = 2'd1; vld[0] = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (!pending && guard < 8);
    vld[0] = 1'b0;
    for (int c = 0; c < MC + 5; c++) begin
      // A different request pulsed while the changeover is still muted.
      vld[0] = (c == 1);
      if (c == 1) begin req[0] = 2'd0; req[1] = 2'd0; end
      in_ch[0] = DW'($urandom); in_ch[1] = DW'($urandom);
      pre1 = in_ch[1];
      tick();
      for (int k = 0; k < nout; k++) begin
        checks++;
        if (gm[k] !== em[k]) begin
          errors++; $display("FAIL ignore_m%0d cyc %0d got %h exp %h", k, c, gm[k], em[k]);
        end
      end
      checks++;
      if ({grdy, gbusy} !== {erdy, ebusy}) begin
        errors++; $display("FAIL ignore_flags cyc %0d got %b%b exp %b%b", c, grdy, gbusy, erdy, ebusy);
      end
    end
    vld[0] = 1'b0;
    checks++;
    if (gm[0] !== pre1 || gm[1] !== pre1) begin
      errors++; $display("FAIL ignore_final got %h_%h exp %h_%h", gm[1], gm[0], pre1, pre1);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_rdy;
    int last_fall, falls;
    do_reset(0);
    vld[0] = 1'b1;
    prev_rdy = grdy;
    last_fall = -1;
    falls = 0;
    for (int c = 0; c < 40; c++) begin
      req[0] = 2'($urandom); req[1] = 2'($urandom);
      in_ch[0] = DW'($urandom); in_ch[1] = DW'($urandom);
      tick();
      for (int k = 0; k < nout; k++) begin
        checks++;
        if (gm[k] !== em[k]) begin
          errors++; $display("FAIL b2b_m%0d cyc %0d got %h exp %h", k, c, gm[k], em[k]);
        end
      end
      checks++;
      if ({grdy, gbusy} !== {erdy, ebusy}) begin
        errors++; $display("FAIL b2b_flags cyc %0d got %b%b exp %b%b", c, grdy, gbusy, erdy, ebusy);
      end
      if (prev_rdy === 1'b1 && grdy === 1'b0) begin
        if (last_fall >= 0) begin
          checks++;
          if (c - last_fall !== MC + 2) begin
            errors++; $display("FAIL b2b_period got %0d exp %0d", c - last_fall, MC + 2);
          end
        end
        last_fall = c;
        falls++;
      end
      prev_rdy = grdy;
    end
    vld[0] = 1'b0;
    checks++;
    if (falls < 5) begin
      errors++; $display("FAIL b2b_accepts got %0d exp >=5", falls);
    end
  endtask

  task automatic test_reset_mid_mute();
    logic [DW-1:0] pre0, pre1;
    int guard;
    do_reset(0);
    req[0] = 2'd1; req[1] = 2'd0; vld[0] = 1'b1;
    in_ch[0] = 16'hA5A5; in_ch[1] = 16'h5A5A;
    guard = 0;
    do begin tick(); guard++; end while (!pending && guard < 8);
    vld[0] = 1'b0;
    repeat (2) tick();
    #2 aresetn = 1'b0;
    #1 sample();
    checks++;
    if (gm[0] !== 16'h0 || gm[1] !== 16'h0) begin
      errors++; $display("FAIL midreset_mdata got %h_%h exp 0000_0000", gm[1], gm[0]);
    end
    checks++;
    if (grdy !== 1'b0 || gbusy !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got rdy=%b busy=%b exp 0 0", grdy, gbusy);
    end
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
    for (int c = 0; c < 2 * MC + 4; c++) begin
      in_ch[0] = DW'($urandom); in_ch[1] = DW'($urandom);
      pre0 = in_ch[0]; pre1 = in_ch[1];
      tick();
      for (int k = 0; k < nout; k++) begin
        checks++;
        if (gm[k] !== em[k]) begin
          errors++; $display("FAIL midreset_m%0d cyc %0d got %h exp %h", k, c, gm[k], em[k]);
        end
      end
      checks++;
      if ({grdy, gbusy} !== 2'b10) begin
        errors++; $display("FAIL midreset_idle cyc %0d got %b%b exp 10", c, grdy, gbusy);
      end
    end
    checks++;
    if (gm[0] !== pre0 || gm[1] !== pre1) begin
      errors++; $display("FAIL midreset_default got %h_%h exp %h_%h", gm[1], gm[0], pre1, pre0);
    end
  endtask

  task automatic test_random(input int d);
    do_reset(d);
    for (int c = 0; c < 150; c++) begin
      for (int i = 0; i < 4; i++) in_ch[i] = DW'($urandom);
      for (int k = 0; k < 3; k++) req[k] = 2'($urandom);
      vld[d] = ($urandom_range(0, 2) == 0);
      tick();
      for (int k = 0; k < nout; k++) begin
        checks++;
        if (gm[k] !== em[k]) begin
          errors++; $display("FAIL rand%0d_m%0d cyc %0d got %h exp %h", d, k, c, gm[k], em[k]);
        end
      end
      checks++;
      if ({grdy, gbusy} !== {erdy, ebusy}) begin
        errors++; $display("FAIL rand%0d_flags cyc %0d got %b%b exp %b%b", d, c, grdy, gbusy, erdy, ebusy);
      end
    end
    vld[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_ch[i] = '0;
    for (int k = 0; k < 3; k++) begin req[k] = '0; vld[k] = 1'b0; end
    test_reset();
    test_swap_hold();
    test_zero_fanout();
    test_out_of_range();
    test_ignore_in_mute();
    test_back_to_back();
    test_reset_mid_mute();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
